writeback_arbiter: RTL and testbench

//  Writeback stage directly upstream of the register file write port.
//  - Merges two result sources into the single RF write port: ALU results (single-cycle, no

---
 rtl/writeback_arbiter.sv | 142 ++++++++++++++
 tb/tb_writeback_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU results and FIFO-buffered load results onto the RF write port.
// Optional feature macro WB_STATS_EN adds the wb_commit_cnt / wb_stall_cnt statistics outputs.
module writeback_arbiter #(
    parameter int RF_ADDR_LEN   = 5,
    parameter int RF_DATA_LEN   = 32,
    parameter int LD_FIFO_DEPTH = 4,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           alu_valid,
    input  logic [RF_ADDR_LEN-1:0]         alu_rd_addr,
    input  logic [RF_DATA_LEN-1:0]         alu_data,
    output logic                           alu_stall,
    input  logic                           ld_valid,
    output logic                           ld_ready,
    input  logic [RF_ADDR_LEN-1:0]         ld_rd_addr,
    input  logic [RF_DATA_LEN-1:0]         ld_data,
    output logic [$clog2(LD_FIFO_DEPTH):0] ld_fifo_count,
    output logic                           rf_w_en,
    output logic [RF_ADDR_LEN-1:0]         rf_rd_addr,
    output logic [RF_DATA_LEN-1:0]         rf_rd_data
`ifdef WB_STATS_EN
    ,
    output logic [31:0]                    wb_commit_cnt,
    output logic [31:0]                    wb_stall_cnt
`endif
);
    localparam int PW = $clog2(LD_FIFO_DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [PW:0] FULL = (PW + 1)'(LD_FIFO_DEPTH);
    localparam logic [SW-1:0] LIMIT = SW'(STARVE_LIMIT);

    typedef enum logic {S_ALU_PRI, S_LD_PRI} state_e;

    state_e                 state_q, state_d;
    logic [RF_ADDR_LEN-1:0] fifo_addr_q [LD_FIFO_DEPTH];
    logic [RF_DATA_LEN-1:0] fifo_data_q [LD_FIFO_DEPTH];
    logic [PW-1:0]          wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]            count_q, count_d;
    logic [SW-1:0]          starve_q, starve_d;
    logic                   ld_ready_q, ld_ready_d;
    logic                   rf_w_en_q, rf_w_en_d;
    logic [RF_ADDR_LEN-1:0] rf_addr_q, rf_addr_d;
    logic [RF_DATA_LEN-1:0] rf_data_q, rf_data_d;
    logic                   push, empty, ld_pri, grant_alu, grant_ld, wr;
    logic [RF_ADDR_LEN-1:0] sel_addr;
    logic [RF_DATA_LEN-1:0] sel_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_ALU_PRI;
        end else begin
            state_q <= state_d;
        end
    end

    // A saturated starvation counter forces exactly one load-priority cycle.
    always_comb begin
        state_d = (state_q == S_ALU_PRI && starve_q == LIMIT) ? S_LD_PRI : S_ALU_PRI;
    end

    always_comb begin
        ld_pri    = state_q == S_LD_PRI;
        alu_stall = ld_pri && alu_valid;
        grant_alu = alu_valid && !ld_pri;
        grant_ld  = !empty && (ld_pri || !alu_valid);
    end

    assign push  = ld_valid && ld_ready_q;
    assign empty = count_q == '0;

    always_comb begin
        wptr_d     = wptr_q + PW'(push);
        rptr_d     = rptr_q + PW'(grant_ld);
        count_d    = count_q + (PW + 1)'(push) - (PW + 1)'(grant_ld);
        starve_d   = (empty || grant_ld) ? '0 : (starve_q == LIMIT ? starve_q : starve_q + SW'(1));
        ld_ready_d = count_d != FULL;
    end

    // rd 0 grants are consumed but never reach the register file.
    always_comb begin
        sel_addr  = grant_alu ? alu_rd_addr : fifo_addr_q[rptr_q];
        sel_data  = grant_alu ? alu_data : fifo_data_q[rptr_q];
        wr        = (grant_alu || grant_ld) && sel_addr != '0;
        rf_w_en_d = wr;
        rf_addr_d = wr ? sel_addr : rf_addr_q;
        rf_data_d = wr ? sel_data : rf_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            starve_q   <= '0;
            ld_ready_q <= 1'b0;
            rf_w_en_q  <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            starve_q   <= starve_d;
            ld_ready_q <= ld_ready_d;
            rf_w_en_q  <= rf_w_en_d;
            rf_addr_q  <= rf_addr_d;
            rf_data_q  <= rf_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wptr_q] <= ld_rd_addr;
            fifo_data_q[wptr_q] <= ld_data;
        end
    end

    assign ld_ready      = ld_ready_q;
    assign ld_fifo_count = count_q;
    assign rf_w_en       = rf_w_en_q;
    assign rf_rd_addr    = rf_addr_q;
    assign rf_rd_data    = rf_data_q;

`ifdef WB_STATS_EN
    logic [31:0] commit_q, stall_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            commit_q <= '0;
            stall_q  <= '0;
        end else begin
            commit_q <= commit_q + 32'(rf_w_en_q);
            stall_q  <= stall_q + 32'(alu_stall);
        end
    end

    assign wb_commit_cnt = commit_q;
    assign wb_stall_cnt  = stall_q;
`endif
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: directed vector table, multi-cycle corner sequences and a randomized
// run against a queue-based reference model of the writeback arbiter.
module tb_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        w;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        st;
        logic        rd;
        logic [2:0]  c;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd_addr;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd_addr;
    logic [31:0] ld_data;
    logic [2:0]  ld_fifo_count;
    logic        rf_w_en;
    logic [4:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
`ifdef WB_STATS_EN
    logic [31:0] wb_commit_cnt, wb_stall_cnt;
    logic [31:0] m_commit, m_stallc;
`endif

    int n_cmp = 0;
    int n_err = 0;

    vec_t tv[20];
    ent_t mq[$];
    bit          m_forced, m_ready, m_wen;
    int          m_starve;
    logic [4:0]  m_addr;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    writeback_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd_addr(alu_rd_addr), .alu_data(alu_data), .alu_stall(alu_stall),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd_addr(ld_rd_addr), .ld_data(ld_data),
        .ld_fifo_count(ld_fifo_count),
        .rf_w_en(rf_w_en), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data)
`ifdef WB_STATS_EN
        , .wb_commit_cnt(wb_commit_cnt), .wb_stall_cnt(wb_stall_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad, logic lv, logic [4:0] la,
                                logic [31:0] ld, logic w, logic [4:0] wa, logic [31:0] wd,
                                logic st, logic rd, logic [2:0] c);
        vec_t v;
        v = '{av, aa, ad, lv, la, ld, w, wa, wd, st, rd, c};
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        m_forced = 0;
        m_ready  = 0;
        m_wen    = 0;
        m_starve = 0;
        m_addr   = '0;
        m_data   = '0;
`ifdef WB_STATS_EN
        m_commit = '0;
        m_stallc = '0;
`endif
    endtask

    // Advance the reference model across one rising edge using the inputs now applied.
    task automatic model_step();
        int sz;
        bit at, lt, ps, st, fn;
        sz = mq.size();
        at = alu_valid && !m_forced;
        lt = sz > 0 && (m_forced || !alu_valid);
        ps = ld_valid && m_ready;
        st = m_forced && alu_valid;
`ifdef WB_STATS_EN
        m_commit = m_commit + 32'(m_wen);
        m_stallc = m_stallc + 32'(st);
`endif
        m_wen = 0;
        if (at) begin
            if (alu_rd_addr != 0) begin
                m_wen = 1;
                m_addr = alu_rd_addr;
                m_data = alu_data;
            end
        end else if (lt) begin
            if (mq[0].a != 0) begin
                m_wen = 1;
                m_addr = mq[0].a;
                m_data = mq[0].d;
            end
        end
        fn = !m_forced && m_starve == LIMIT;
        m_starve = (sz == 0 || lt) ? 0 : (m_starve < LIMIT ? m_starve + 1 : LIMIT);
        m_forced = fn;
        if (lt) void'(mq.pop_front());
        if (ps) mq.push_back('{ld_rd_addr, ld_data});
        m_ready = mq.size() != DEPTH;
    endtask

    initial begin
        int pushed, wrote, maxc, apct;
        bit saw_block, hold_alu, hold_ld, exp_stall;

        tv[0]  = mk(0, 0, 0,     0, 0, 0,     0, 0, 0,     0, 0, 0);
        tv[1]  = mk(1, 5, 'h2A,  0, 0, 0,     0, 0, 0,     0, 1, 0);
        tv[2]  = mk(0, 0, 0,     0, 0, 0,     1, 5, 'h2A,  0, 1, 0);
        tv[3]  = mk(0, 0, 0,     0, 0, 0,     0, 5, 'h2A,  0, 1, 0);
        tv[4]  = mk(0, 0, 0,     1, 6, 'h10,  0, 5, 'h2A,  0, 1, 0);
        tv[5]  = mk(0, 0, 0,     1, 7, 'h11,  0, 5, 'h2A,  0, 1, 1);
        tv[6]  = mk(0, 0, 0,     1, 8, 'h12,  1, 6, 'h10,  0, 1, 1);
        tv[7]  = mk(0, 0, 0,     1, 9, 'h13,  1, 7, 'h11,  0, 1, 1);
        tv[8]  = mk(0, 0, 0,     0, 0, 0,     1, 8, 'h12,  0, 1, 1);
        tv[9]  = mk(0, 0, 0,     0, 0, 0,     1, 9, 'h13,  0, 1, 0);
        tv[10] = mk(0, 0, 0,     0, 0, 0,     0, 9, 'h13,  0, 1, 0);
        tv[11] = mk(1, 3, 'h33,  1, 4, 'h44,  0, 9, 'h13,  0, 1, 0);
        tv[12] = mk(1, 3, 'h33,  0, 0, 0,     1, 3, 'h33,  0, 1, 1);
        tv[13] = mk(1, 3, 'h33,  0, 0, 0,     1, 3, 'h33,  0, 1, 1);
        tv[14] = mk(1, 3, 'h33,  0, 0, 0,     1, 3, 'h33,  0, 1, 1);
        tv[15] = mk(1, 3, 'h33,  0, 0, 0,     1, 3, 'h33,  0, 1, 1);
        tv[16] = mk(1, 3, 'h33,  0, 0, 0,     1, 3, 'h33,  1, 1, 1);
        tv[17] = mk(1, 3, 'h33,  0, 0, 0,     1, 4, 'h44,  0, 1, 0);
        tv[18] = mk(0, 0, 0,     0, 0, 0,     1, 3, 'h33,  0, 1, 0);
        tv[19] = mk(0, 0, 0,     0, 0, 0,     0, 3, 'h33,  0, 1, 0);

        rst = 1'b0;
        alu_valid = 0; alu_rd_addr = 0; alu_data = 0;
        ld_valid = 0; ld_rd_addr = 0; ld_data = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wen", 64'(rf_w_en), 0);
        chk("rst_addr", 64'(rf_rd_addr), 0);
        chk("rst_data", 64'(rf_rd_data), 0);
        chk("rst_ready", 64'(ld_ready), 0);
        chk("rst_count", 64'(ld_fifo_count), 0);
        chk("rst_stall", 64'(alu_stall), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        for (int i = 0; i < 20; i++) begin
            alu_valid = tv[i].av; alu_rd_addr = tv[i].aa; alu_data = tv[i].ad;
            ld_valid = tv[i].lv; ld_rd_addr = tv[i].la; ld_data = tv[i].ld;
            @(negedge clk);
            chk($sformatf("v%0d_wen", i), 64'(rf_w_en), 64'(tv[i].w));
            chk($sformatf("v%0d_addr", i), 64'(rf_rd_addr), 64'(tv[i].wa));
            chk($sformatf("v%0d_data", i), 64'(rf_rd_data), 64'(tv[i].wd));
            chk($sformatf("v%0d_stall", i), 64'(alu_stall), 64'(tv[i].st));
            chk($sformatf("v%0d_ready", i), 64'(ld_ready), 64'(tv[i].rd));
            chk($sformatf("v%0d_count", i), 64'(ld_fifo_count), 64'(tv[i].c));
            @(posedge clk);
            #1;
        end

        // ALU saturating the port while five loads arrive back-to-back.
        alu_valid = 1; alu_rd_addr = 1; alu_data = 'hA1;
        pushed = 0; wrote = 0; maxc = 0; saw_block = 0;
        for (int cyc = 0; cyc < 100 && wrote < 5; cyc++) begin
            ld_valid = pushed < 5;
            ld_rd_addr = 5'(10 + pushed);
            ld_data = 32'h100 + 32'(pushed);
            @(negedge clk);
            if (int'(ld_fifo_count) > maxc) maxc = int'(ld_fifo_count);
            if (rf_w_en && rf_rd_addr != 1) begin
                chk("t5_order_addr", 64'(rf_rd_addr), 64'(10 + wrote));
                chk("t5_order_data", 64'(rf_rd_data), 64'(32'h100 + 32'(wrote)));
                wrote++;
            end
            if (ld_valid && !ld_ready && pushed == 4) saw_block = 1;
            if (ld_valid && ld_ready) pushed++;
            @(posedge clk);
            #1;
        end
        chk("t5_written", 64'(wrote), 5);
        chk("t5_peak_count", 64'(maxc), 4);
        chk("t5_fifth_blocked", 64'(saw_block), 1);
        alu_valid = 0; ld_valid = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end

        // rd 0 grants from both sources, then reset while the FIFO is draining.
        alu_valid = 1; alu_rd_addr = 0; alu_data = 'h77;
        ld_valid = 1; ld_rd_addr = 0; ld_data = 'h55;
        for (int p = 0; p < 5; p++) begin
            if (p == 3) begin
                alu_valid = 0;
                ld_valid = 0;
            end
            @(negedge clk);
            if (p > 0) chk("t6_wen_rd0", 64'(rf_w_en), 0);
            if (p < 3) chk("t6_stall", 64'(alu_stall), 0);
            if (p == 3) chk("t6_count3", 64'(ld_fifo_count), 3);
            if (p == 4) chk("t6_count2", 64'(ld_fifo_count), 2);
            if (p < 4) begin
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b0;
        #1;
        chk("t6_rst_count", 64'(ld_fifo_count), 0);
        chk("t6_rst_wen", 64'(rf_w_en), 0);
        chk("t6_rst_ready", 64'(ld_ready), 0);
        @(posedge clk);
        #1 rst = 1'b1;

        model_reset();
        hold_alu = 0;
        hold_ld = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            apct = ((cyc / 500) % 2 == 1) ? 90 : 40;
            if (!hold_alu) begin
                alu_valid = $urandom_range(0, 99) < apct;
                alu_rd_addr = 5'($urandom_range(0, 7));
                alu_data = $urandom;
            end
            if (!hold_ld) begin
                ld_valid = $urandom_range(0, 1) == 1;
                ld_rd_addr = 5'($urandom_range(0, 7));
                ld_data = $urandom;
            end
            @(negedge clk);
            exp_stall = m_forced && alu_valid;
            chk("rnd_stall", 64'(alu_stall), 64'(exp_stall));
            chk("rnd_ready", 64'(ld_ready), 64'(m_ready));
            chk("rnd_count", 64'(ld_fifo_count), 64'(mq.size()));
            chk("rnd_wen", 64'(rf_w_en), 64'(m_wen));
            if (m_wen) begin
                chk("rnd_addr", 64'(rf_rd_addr), 64'(m_addr));
                chk("rnd_data", 64'(rf_rd_data), 64'(m_data));
            end
`ifdef WB_STATS_EN
            chk("rnd_commit_cnt", 64'(wb_commit_cnt), 64'(m_commit));
            chk("rnd_stall_cnt", 64'(wb_stall_cnt), 64'(m_stallc));
`endif
            hold_alu = exp_stall;
            hold_ld = ld_valid && !m_ready;
            model_step();
            @(posedge clk);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
